// File: rtl/proc_cache_pkg.sv
// Shared opcodes, bus-direction codes and line layout for proc_cache.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package proc_cache_pkg;

  // Default geometry: 8-bit address, one byte per line, 16 lines.
  localparam int CACHE_ADDR_W = 8;
  localparam int CACHE_DATA_W = 8;
  localparam int CACHE_LINES  = 16;
  localparam int CACHE_IDX_W  = $clog2(CACHE_LINES);
  localparam int CACHE_TAG_W  = CACHE_ADDR_W - CACHE_IDX_W;

  // Load/store unit opcodes; every other encoding is a no-op for the cache.
  localparam logic [3:0] OP_LOAD  = 4'b1000;
  localparam logic [3:0] OP_STORE = 4'b1001;

  // Bus direction as reported by the load/store unit.
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // One cache line at the default geometry.
  typedef struct packed {
    logic                    valid;
    logic [CACHE_TAG_W-1:0]  tag;
    logic [CACHE_DATA_W-1:0] data;
  } line_t;

endpackage

// File: rtl/proc_cache_array.sv
// Line storage: LINES entries, one combinational read port, one write port.
// Latency: read 0 cycles; write visible the cycle after the write edge.
// Backpressure: none; the caller qualifies wr_en. Reset clears every entry.
module proc_cache_array #(
  parameter int LINES   = 16,
  parameter int ENTRY_W = 13
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [$clog2(LINES)-1:0] rd_idx,
  output logic [ENTRY_W-1:0]       rd_entry,
  input  logic                     wr_en,
  input  logic [$clog2(LINES)-1:0] wr_idx,
  input  logic [ENTRY_W-1:0]       wr_entry
);

  logic [LINES-1:0][ENTRY_W-1:0] mem_q;
  logic [LINES-1:0][ENTRY_W-1:0] mem_d;

  // Next array state: hold everything, overwrite the addressed entry on a write.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_idx] = wr_entry;
    end
  end

  // Array registers; reset wins over any pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Asynchronous read of the addressed entry.
  always_comb begin
    rd_entry = mem_q[rd_idx];
  end

endmodule

// File: rtl/proc_cache.sv
// Direct-mapped write-through byte cache; build with PROC_CACHE_WRITE_ALLOCATE_EN to allocate on store miss.
// Latency: lookup (data/miss) combinational; fills and stores land on the next rising edge.
// Backpressure: busy=1 suppresses the array write for that cycle; the cache never drives the bus.
module proc_cache
  import proc_cache_pkg::*;
#(
  parameter int ADDR_W = CACHE_ADDR_W,
  parameter int DATA_W = CACHE_DATA_W,
  parameter int LINES  = CACHE_LINES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] input_data,
  input  logic              rw,
  input  logic              busy,
  output logic [DATA_W-1:0] data,
  output logic              miss
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  // Line layout at this instance's geometry (matches line_t at defaults).
  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } entry_t;

`ifdef PROC_CACHE_WRITE_ALLOCATE_EN
  localparam logic ALLOC_ON_STORE_MISS = 1'b1;
`else
  localparam logic ALLOC_ON_STORE_MISS = 1'b0;
`endif

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  entry_t           rd_line;
  entry_t           wr_line;
  logic             hit;
  logic             is_load;
  logic             is_store;
  logic             fill_we;
  logic             store_we;
  logic             wr_en;

  // Address split, hit compare and the processor-facing lookup outputs.
  always_comb begin
    idx      = address[IDX_W-1:0];
    tag      = address[ADDR_W-1:IDX_W];
    is_load  = (op == OP_LOAD);
    is_store = (op == OP_STORE);
    hit      = rd_line.valid && (rd_line.tag == tag);
    miss     = is_load && !hit;
    data     = (hit && (is_load || is_store)) ? rd_line.data : '0;
  end

  // Write qualification: fill on a load miss with a read bus cycle, update on a
  // store with a write bus cycle (hits only unless allocating); busy holds off both.
  always_comb begin
    fill_we  = is_load && !hit && (rw == RW_READ) && !busy;
    store_we = is_store && (rw == RW_WRITE) && !busy && (hit || ALLOC_ON_STORE_MISS);
    wr_en    = fill_we || store_we;
    wr_line  = '{valid: 1'b1, tag: tag, data: input_data};
  end

  proc_cache_array #(
    .LINES   (LINES),
    .ENTRY_W ($bits(entry_t))
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (idx),
    .rd_entry (rd_line),
    .wr_en    (wr_en),
    .wr_idx   (idx),
    .wr_entry (wr_line)
  );

endmodule

// File: tb/tb_proc_cache.sv
// Directed, table-driven bench for proc_cache plus a hand-written reset sequence.
// Latency: each vector checks the combinational lookup before clocking its edges.
// Backpressure: busy is driven explicitly per vector.
module tb_proc_cache;

  localparam logic [3:0] LD  = 4'b1000;
  localparam logic [3:0] ST  = 4'b1001;
  localparam logic [3:0] NOP = 4'b0000;
  localparam logic [3:0] OTH = 4'b1010;

`ifdef PROC_CACHE_WRITE_ALLOCATE_EN
  localparam logic ALLOC = 1'b1;
`else
  localparam logic ALLOC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] address;
  logic [3:0] op;
  logic [7:0] input_data;
  logic       rw;
  logic       busy;
  logic [7:0] data;
  logic       miss;

  int n_checks = 0;
  int n_fails  = 0;

  proc_cache dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .op         (op),
    .input_data (input_data),
    .rw         (rw),
    .busy       (busy),
    .data       (data),
    .miss       (miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [7:0] addr;
    logic       rw;
    logic       busy;
    logic [7:0] din;
    int         edges;
    logic       exp_miss;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic [3:0] o, logic [7:0] a, logic r, logic b,
                              logic [7:0] d, int e, logic em, logic [7:0] ed);
    vec_t v;
    v.op = o; v.addr = a; v.rw = r; v.busy = b; v.din = d;
    v.edges = e; v.exp_miss = em; v.exp_data = ed;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [3:0] o, logic [7:0] a, logic r, logic b, logic [7:0] d);
    op = o; address = a; rw = r; busy = b; input_data = d;
  endtask

  initial begin
    // Vectors: lookup is checked first, then 'edges' clock edges are applied.
    //   op   addr   rw    busy  din    edg miss  data
    add(LD,  8'h25, 1'b1, 1'b1, 8'h00, 0, 1'b1, 8'h00); // 0 reset state miss
    add(LD,  8'h25, 1'b1, 1'b0, 8'hA5, 1, 1'b1, 8'h00); // 1 fill edge
    add(LD,  8'h25, 1'b1, 1'b1, 8'h00, 0, 1'b0, 8'hA5); // 2 hit after fill
    add(NOP, 8'h25, 1'b1, 1'b0, 8'h00, 1, 1'b0, 8'h00); // 3 other op: no data, no write
    add(ST,  8'h25, 1'b1, 1'b1, 8'h00, 0, 1'b0, 8'hA5); // 4 store hit shows data
    add(LD,  8'h35, 1'b1, 1'b0, 8'h3C, 1, 1'b1, 8'h00); // 5 conflict fill idx 5
    add(LD,  8'h35, 1'b1, 1'b1, 8'h00, 0, 1'b0, 8'h3C); // 6 new occupant hits
    add(LD,  8'h25, 1'b1, 1'b1, 8'h00, 0, 1'b1, 8'h00); // 7 old occupant evicted
    add(ST,  8'h35, 1'b0, 1'b0, 8'h77, 1, 1'b0, 8'h3C); // 8 store hit update
    add(LD,  8'h35, 1'b1, 1'b1, 8'h00, 0, 1'b0, 8'h77); // 9 updated value
    add(LD,  8'h35, 1'b1, 1'b0, 8'h99, 1, 1'b0, 8'h77); // 10 load hit must not write
    add(LD,  8'h35, 1'b1, 1'b1, 8'h00, 0, 1'b0, 8'h77); // 11
    add(ST,  8'h35, 1'b1, 1'b0, 8'hEE, 1, 1'b0, 8'h77); // 12 store with rw=read ignored
    add(LD,  8'h35, 1'b1, 1'b1, 8'h00, 0, 1'b0, 8'h77); // 13
    add(LD,  8'h40, 1'b1, 1'b1, 8'h5E, 3, 1'b1, 8'h00); // 14 busy blocks fill x3
    add(LD,  8'h40, 1'b1, 1'b1, 8'h5E, 0, 1'b1, 8'h00); // 15 still missing
    add(LD,  8'h40, 1'b1, 1'b0, 8'h5E, 1, 1'b1, 8'h00); // 16 busy dropped, fill
    add(LD,  8'h40, 1'b1, 1'b1, 8'h00, 0, 1'b0, 8'h5E); // 17 hit one edge later
    add(LD,  8'h61, 1'b0, 1'b0, 8'h42, 1, 1'b1, 8'h00); // 18 load with rw=write: no fill
    add(LD,  8'h61, 1'b1, 1'b1, 8'h00, 0, 1'b1, 8'h00); // 19
    add(OTH, 8'h3B, 1'b1, 1'b0, 8'h22, 1, 1'b0, 8'h00); // 20 unknown op, no write
    add(LD,  8'h3B, 1'b1, 1'b1, 8'h00, 0, 1'b1, 8'h00); // 21
    add(ST,  8'h9A, 1'b0, 1'b0, 8'h11, 1, 1'b0, 8'h00); // 22 store miss
    add(LD,  8'h9A, 1'b1, 1'b1, 8'h00, 0, !ALLOC, ALLOC ? 8'h11 : 8'h00); // 23
    add(ST,  8'h9A, 1'b0, 1'b1, 8'h00, 0, 1'b0, ALLOC ? 8'h11 : 8'h00);   // 24

    reset = 1'b1;
    drive(NOP, 8'h00, 1'b1, 1'b1, 8'h00);
    tick();
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].op, vecs[i].addr, vecs[i].rw, vecs[i].busy, vecs[i].din);
      #1;
      check($sformatf("vec%0d_miss", i), {7'd0, miss}, {7'd0, vecs[i].exp_miss});
      check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
      for (int e = 0; e < vecs[i].edges; e++) tick();
    end

    // Reset with a fill in flight: the fill is discarded and all lines invalidated.
    drive(LD, 8'h7C, 1'b1, 1'b0, 8'h55);
    #1;
    check("pre_reset_7c_miss", {7'd0, miss}, 8'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(LD, 8'h7C, 1'b1, 1'b1, 8'h00);
    tick();

    begin
      logic [7:0] addrs [5];
      addrs[0] = 8'h25; addrs[1] = 8'h35; addrs[2] = 8'h40;
      addrs[3] = 8'h9A; addrs[4] = 8'h7C;
      for (int k = 0; k < 5; k++) begin
        drive(LD, addrs[k], 1'b1, 1'b1, 8'h00);
        #1;
        check($sformatf("post_reset_%h_miss", addrs[k]), {7'd0, miss}, 8'd1);
        check($sformatf("post_reset_%h_data", addrs[k]), data, 8'h00);
      end
      // A store lookup after reset also sees no hit.
      drive(ST, 8'h35, 1'b0, 1'b1, 8'h00);
      #1;
      check("post_reset_store_data", data, 8'h00);
      check("post_reset_store_miss", {7'd0, miss}, 8'd0);
    end

    // Refill after reset works and repeated qualifying edges are harmless.
    drive(LD, 8'h25, 1'b1, 1'b0, 8'hC3);
    tick();
    tick();
    drive(LD, 8'h25, 1'b1, 1'b1, 8'h00);
    #1;
    check("refill_miss", {7'd0, miss}, 8'd0);
    check("refill_data", data, 8'hC3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
